board_color_ram: RTL and testbench

- Downstream of the game-logic stage; holds the colour of every settled and falling cell on the 10x20 board.
- On each frame_clk rising edge it:
  - applies any pending row-clear request by shifting rows down;
  - erases the falling piece's previous cells;
  - paints the current cells in blockColor.
- The VGA renderer reads cells through a registered read port.
- It also keeps a running cleared-line count for the score display.

---
 rtl/board_pkg.sv | 28 ++
 rtl/board_color_ram_edge_pulse.sv | 21 ++
 rtl/board_color_ram.sv | 218 +++++++++++++++++++++
 tb/tb_board_color_ram.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, cell/row types and the frame-update FSM encoding
// for the playfield colour store.
package board_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int COLOR_W = 16;
    localparam int X_IW    = $clog2(BOARD_W);
    localparam int Y_IW    = $clog2(BOARD_H);

    typedef logic [COLOR_W-1:0] cell_t;
    typedef cell_t [BOARD_W-1:0] row_t;
    typedef logic [6:0]         coord_t;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CLEAR,
        ERASE,
        PAINT,
        DONE
    } state_t;

    function automatic logic in_board(input coord_t x, input coord_t y);
        return (x < 7'(BOARD_W)) && (y < 7'(BOARD_H));
    endfunction

endpackage

// File: rtl/board_color_ram_edge_pulse.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of a level input.
module edge_pulse (
    input  logic Clk,
    input  logic Reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/board_color_ram.sv
// Playfield colour store: per frame applies a pending row clear, erases the
// falling piece's previous cells and paints its current cells.
module board_color_ram
    import board_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_clk,
    input  coord_t [3:0] blockXPos,
    input  coord_t [3:0] blockYPos,
    input  coord_t [3:0] blockXPrev,
    input  coord_t [3:0] blockYPrev,
    input  cell_t        blockColor,
    input  logic         Clear_row,
    input  logic [3:0]   Num_rows_to_clear,
    input  coord_t       Row_to_clear,
    input  coord_t       rd_x,
    input  coord_t       rd_y,
    output cell_t        rd_color,
    output logic         busy,
    output logic         frame_done,
    output logic [15:0]  lines_cleared
);

    logic frame_evt;
    logic clear_evt;

    edge_pulse u_frame_edge (.Clk(Clk), .Reset(Reset), .level(frame_clk), .pulse(frame_evt));
    edge_pulse u_clear_edge (.Clk(Clk), .Reset(Reset), .level(Clear_row), .pulse(clear_evt));

    state_t       state_reg, state_next;
    logic         frm_pend_reg, clr_pend_reg;
    coord_t       clr_row_reg;
    logic [3:0]   clr_num_reg;
    coord_t [3:0] pos_x_reg, pos_y_reg, prev_x_reg, prev_y_reg;
    cell_t        color_reg;
    logic         erase_skip_reg;
    logic [4:0]   row_cnt_reg;
    logic [4:0]   clr_n_reg;
    logic [1:0]   idx_reg;
    logic [15:0]  lines_reg;
    cell_t        rd_color_reg;

    row_t         board [BOARD_H];

    logic         row_we;
    row_t         row_data;
    logic         cell_we;
    coord_t       cell_x, cell_y;
    cell_t        cell_data;
    logic         clr_done;
    logic         erase_hit;
    logic         prev_same_in;
    logic         clr_valid;
    logic [4:0]   clr_limit;
    logic [4:0]   clr_n_calc;
    logic [16:0]  lines_sum;

    // All four previous cells identical marks a freshly spawned piece: nothing to erase.
    always_comb begin
        prev_same_in = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if (blockXPrev[i] != blockXPrev[0] || blockYPrev[i] != blockYPrev[0]) begin
                prev_same_in = 1'b0;
            end
        end
    end

    always_comb begin
        erase_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pos_x_reg[i] == prev_x_reg[idx_reg] && pos_y_reg[i] == prev_y_reg[idx_reg]) begin
                erase_hit = 1'b1;
            end
        end
    end

    // Rows removed can never exceed the rows at or above the bottom-most cleared row.
    always_comb begin
        clr_valid = clr_row_reg < 7'(BOARD_H);
        clr_limit = clr_row_reg[4:0] + 5'd1;
        if (!clr_valid) begin
            clr_n_calc = 5'd0;
        end else if ({1'b0, clr_num_reg} > clr_limit) begin
            clr_n_calc = clr_limit;
        end else begin
            clr_n_calc = {1'b0, clr_num_reg};
        end
    end

    always_comb begin
        state_next = state_reg;
        row_we     = 1'b0;
        row_data   = '0;
        cell_we    = 1'b0;
        cell_x     = '0;
        cell_y     = '0;
        cell_data  = '0;
        clr_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frm_pend_reg) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (clr_pend_reg)      state_next = CLEAR;
                else if (prev_same_in) state_next = PAINT;
                else                   state_next = ERASE;
            end
            CLEAR: begin
                if (clr_n_reg != 5'd0) begin
                    row_we   = 1'b1;
                    row_data = (row_cnt_reg >= clr_n_reg) ? board[row_cnt_reg - clr_n_reg] : '0;
                end
                if (clr_n_reg == 5'd0 || row_cnt_reg == 5'd0) begin
                    clr_done   = 1'b1;
                    state_next = erase_skip_reg ? PAINT : ERASE;
                end
            end
            ERASE: begin
                cell_x  = prev_x_reg[idx_reg];
                cell_y  = prev_y_reg[idx_reg];
                cell_we = !erase_hit;
                if (idx_reg == 2'd3) state_next = PAINT;
            end
            PAINT: begin
                cell_x    = pos_x_reg[idx_reg];
                cell_y    = pos_y_reg[idx_reg];
                cell_data = color_reg;
                cell_we   = 1'b1;
                if (idx_reg == 2'd3) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!in_board(cell_x, cell_y)) cell_we = 1'b0;
    end

    assign lines_sum = {1'b0, lines_reg} + {12'd0, clr_n_reg};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            frm_pend_reg   <= 1'b0;
            clr_pend_reg   <= 1'b0;
            clr_row_reg    <= '0;
            clr_num_reg    <= '0;
            pos_x_reg      <= '0;
            pos_y_reg      <= '0;
            prev_x_reg     <= '0;
            prev_y_reg     <= '0;
            color_reg      <= '0;
            erase_skip_reg <= 1'b0;
            row_cnt_reg    <= '0;
            clr_n_reg      <= '0;
            idx_reg        <= '0;
            lines_reg      <= '0;
            rd_color_reg   <= '0;
        end else begin
            state_reg <= state_next;

            // A frame edge arriving while one is already pending is dropped.
            if (state_reg == IDLE && frm_pend_reg) frm_pend_reg <= 1'b0;
            else if (frame_evt)                    frm_pend_reg <= 1'b1;

            if (clear_evt) begin
                clr_pend_reg <= 1'b1;
                clr_row_reg  <= Row_to_clear;
                clr_num_reg  <= Num_rows_to_clear;
            end else if (clr_done) begin
                clr_pend_reg <= 1'b0;
            end

            if (state_reg == CAPTURE) begin
                pos_x_reg      <= blockXPos;
                pos_y_reg      <= blockYPos;
                prev_x_reg     <= blockXPrev;
                prev_y_reg     <= blockYPrev;
                color_reg      <= blockColor;
                erase_skip_reg <= prev_same_in;
                row_cnt_reg    <= clr_valid ? clr_row_reg[4:0] : 5'd0;
                clr_n_reg      <= clr_n_calc;
            end

            if (state_reg == CLEAR && !clr_done) row_cnt_reg <= row_cnt_reg - 5'd1;

            if (clr_done) lines_reg <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];

            if (state_reg == ERASE || state_reg == PAINT) idx_reg <= idx_reg + 2'd1;

            rd_color_reg <= in_board(rd_x, rd_y) ? board[rd_y[Y_IW-1:0]][rd_x[X_IW-1:0]] : '0;
        end
    end

    // One register per row so a whole row can be shifted in a single cycle.
    for (genvar gi = 0; gi < BOARD_H; gi++) begin : g_row
        row_t row_reg;
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                row_reg <= '0;
            end else if (row_we && row_cnt_reg == 5'(gi)) begin
                row_reg <= row_data;
            end else if (cell_we && cell_y == 7'(gi)) begin
                row_reg[cell_x[X_IW-1:0]] <= cell_data;
            end
        end
        assign board[gi] = row_reg;
    end

    assign rd_color      = rd_color_reg;
    assign busy          = (state_reg != IDLE);
    assign frame_done    = (state_reg == DONE);
    assign lines_cleared = lines_reg;

endmodule

// File: tb/tb_board_color_ram.sv
// Self-checking bench for board_color_ram against a whole-board reference model.
module tb_board_color_ram;
    import board_pkg::*;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         frame_clk;
    logic         Clear_row;
    coord_t [3:0] bx, by, bxp, byp;
    cell_t        color;
    logic [3:0]   nclr;
    coord_t       rclr;
    coord_t       rd_x, rd_y;
    cell_t        rd_color;
    logic         busy, frame_done;
    logic [15:0]  lines;

    board_color_ram dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .blockXPos(bx), .blockYPos(by), .blockXPrev(bxp), .blockYPrev(byp),
        .blockColor(color), .Clear_row(Clear_row), .Num_rows_to_clear(nclr),
        .Row_to_clear(rclr), .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
        .busy(busy), .frame_done(frame_done), .lines_cleared(lines)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int frame_no = 0;

    logic [15:0] mdl [20][10];
    int mdl_lines;
    int cx[4], cy[4], px[4], py[4];
    int ccol;
    bit clr_req;
    int crow, cn;
    int exp_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                mdl[y][x] = 16'h0;
        mdl_lines = 0;
        clr_req = 0;
    endtask

    function automatic bit on_board(input int x, input int y);
        return x >= 0 && x < 10 && y >= 0 && y < 20;
    endfunction

    // Frame result from the rules: clear, then erase old cells, then paint new ones.
    task automatic model_frame();
        logic [15:0] old [20][10];
        int n;
        bit same, hit;
        exp_lat = 7;
        if (clr_req) begin
            n = 0;
            if (crow < 20) n = (cn > crow + 1) ? crow + 1 : cn;
            exp_lat += (n == 0) ? 1 : crow + 1;
            old = mdl;
            if (n > 0)
                for (int y = 0; y <= crow; y++)
                    for (int x = 0; x < 10; x++)
                        mdl[y][x] = (y - n >= 0) ? old[y - n][x] : 16'h0;
            mdl_lines = (mdl_lines + n > 65535) ? 65535 : mdl_lines + n;
            clr_req = 0;
        end
        same = 1;
        for (int i = 1; i < 4; i++)
            if (px[i] != px[0] || py[i] != py[0]) same = 0;
        if (!same) begin
            exp_lat += 4;
            for (int i = 0; i < 4; i++) begin
                hit = 0;
                for (int j = 0; j < 4; j++)
                    if (cx[j] == px[i] && cy[j] == py[i]) hit = 1;
                if (!hit && on_board(px[i], py[i])) mdl[py[i]][px[i]] = 16'h0;
            end
        end
        for (int i = 0; i < 4; i++)
            if (on_board(cx[i], cy[i])) mdl[cy[i]][cx[i]] = ccol[15:0];
    endtask

    task automatic set_pos(input int x0, y0, x1, y1, x2, y2, x3, y3);
        cx[0] = x0; cy[0] = y0; cx[1] = x1; cy[1] = y1;
        cx[2] = x2; cy[2] = y2; cx[3] = x3; cy[3] = y3;
    endtask

    task automatic prev_sentinel();
        for (int i = 0; i < 4; i++) begin px[i] = 0; py[i] = 0; end
    endtask

    task automatic prev_from_pos();
        for (int i = 0; i < 4; i++) begin px[i] = cx[i]; py[i] = cy[i]; end
    endtask

    task automatic request_clear(input int row, input int num);
        @(negedge Clk);
        rclr = 7'(row);
        nclr = 4'(num);
        Clear_row = 1'b1;
        @(negedge Clk);
        Clear_row = 1'b0;
        clr_req = 1;
        crow = row;
        cn = num;
    endtask

    task automatic read_cell(input int x, input int y, output logic [15:0] val);
        @(negedge Clk);
        rd_x = 7'(x);
        rd_y = 7'(y);
        @(posedge Clk);
        @(negedge Clk);
        val = rd_color;
    endtask

    task automatic check_board();
        logic [15:0] v;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                read_cell(x, y, v);
                check($sformatf("cell(%0d,%0d)", x, y), v, mdl[y][x]);
            end
        check("lines_cleared", lines, mdl_lines);
    endtask

    task automatic do_frame();
        int lat;
        bit seen;
        model_frame();
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            bx[i]  = 7'(cx[i]);
            by[i]  = 7'(cy[i]);
            bxp[i] = 7'(px[i]);
            byp[i] = 7'(py[i]);
        end
        color = ccol[15:0];
        frame_clk = 1'b1;
        lat = 0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            lat++;
            if (lat == 2) check("busy_in_frame", busy, 1'b1);
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        check("frame_latency", seen ? lat : 32'hFFFF_FFFF, exp_lat);
        @(posedge Clk);
        @(negedge Clk);
        check("frame_done_width", frame_done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        frame_clk = 1'b0;
        frame_no++;
        $display("frame %0d: latency=%0d expected=%0d lines=%0d", frame_no, lat, exp_lat, lines);
    endtask

    initial begin
        logic [15:0] v;
        Reset = 1'b1; frame_clk = 1'b0; Clear_row = 1'b0;
        bx = '0; by = '0; bxp = '0; byp = '0; color = '0;
        nclr = '0; rclr = '0; rd_x = '0; rd_y = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check("reset_busy", busy, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_lines", lines, 16'h0);
        check("reset_rd_color", rd_color, 16'h0);
        Reset = 1'b0;
        check_board();

        // Spawn: prev sentinel, so no erase phase.
        prev_sentinel();
        set_pos(4, 0, 4, 1, 5, 1, 5, 2);
        ccol = 16'h0f00;
        do_frame();
        check_board();
        read_cell(0, 0, v);
        check("origin_untouched", v, 16'h0);

        // Drop one row: overlapping cells stay painted.
        prev_from_pos();
        set_pos(4, 1, 4, 2, 5, 2, 5, 3);
        do_frame();
        check_board();
        read_cell(4, 0, v);
        check("vacated_cell", v, 16'h0);
        read_cell(5, 2, v);
        check("overlap_cell", v, 16'h0f00);

        // Fill the bottom row, mark (3,18), then clear one line.
        prev_sentinel();
        ccol = 16'h05f0;
        set_pos(0, 19, 1, 19, 2, 19, 3, 19); do_frame();
        set_pos(4, 19, 5, 19, 6, 19, 7, 19); do_frame();
        set_pos(8, 19, 9, 19, 9, 19, 9, 19); do_frame();
        ccol = 16'h00a8;
        set_pos(3, 18, 3, 18, 3, 18, 3, 18); do_frame();
        request_clear(19, 1);
        ccol = 16'h1234;
        set_pos(12, 25, 12, 25, 12, 25, 12, 25);
        do_frame();
        check_board();
        read_cell(3, 19, v);
        check("shifted_cell", v, 16'h00a8);
        check("lines_after_clear", lines, 16'd1);

        // Off-board coordinates leave the board untouched.
        ccol = 16'h7777;
        set_pos(12, 3, 2, 25, 12, 25, 12, 5);
        do_frame();
        check_board();
        read_cell(12, 5, v);
        check("oob_read", v, 16'h0);

        // Randomized frames with occasional clears, some ignored or clamped.
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 2) != 0) prev_from_pos();
            else prev_sentinel();
            for (int i = 0; i < 4; i++) begin
                cx[i] = $urandom_range(0, 11);
                cy[i] = $urandom_range(0, 21);
            end
            ccol = $urandom_range(1, 65535);
            if ($urandom_range(0, 2) == 0)
                request_clear($urandom_range(0, 21), $urandom_range(0, 5));
            do_frame();
            check_board();
        end

        // Reset in the middle of a row clear discards everything.
        request_clear(19, 2);
        prev_sentinel();
        set_pos(1, 1, 2, 2, 3, 3, 4, 4);
        ccol = 16'h0abc;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        check("busy_in_clear", busy, 1'b1);
        Reset = 1'b1;
        #1;
        check("busy_on_reset", busy, 1'b0);
        @(negedge Clk);
        frame_clk = 1'b0;
        Reset = 1'b0;
        model_reset();
        check_board();
        check("lines_after_reset", lines, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
